// File: rtl/uart_frame_loader.sv
// Receives a framed image over UART (AA 55 header + FRAME_PIXELS bytes), writes each
// pixel to BRAM, and replies ACK or NAK to the host once the frame completes or aborts.
module uart_frame_loader #(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_error,
  output logic [7:0]  wr_data,
  output logic [18:0] wr_addr,
  output logic        wr_en,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_done,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] REPLY = 2'd3;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [18:0]   PIX_LAST = 19'(FRAME_PIXELS - 1);

  logic [1:0]    state;
  logic [18:0]   counter;
  logic [TW-1:0] tmo;
  logic [7:0]    reply;

  assign fsm_state = state;

  // Pulse outputs default low each cycle; the idle timer restarts on any received byte
  // and on every state change so a transfer only aborts after a true silent gap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      tmo        <= '0;
      reply      <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (rx_valid && !rx_frame_error && rx_data == SYNC0)
            state <= HDR;
        end
        HDR: begin
          if (rx_valid) begin
            tmo <= '0;
            if (rx_frame_error) begin
              state <= IDLE;
            end else if (rx_data == SYNC1) begin
              state   <= LOAD;
              counter <= '0;
            end else if (rx_data != SYNC0) begin
              state <= IDLE;
            end
          end else if (tmo == TMO_LAST) begin
            state <= IDLE;
            tmo   <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        LOAD: begin
          if (rx_valid) begin
            tmo <= '0;
            if (rx_frame_error) begin
              state <= REPLY;
              reply <= NAK_BYTE;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= rx_data;
              wr_addr <= counter;
              if (counter == PIX_LAST) begin
                counter <= '0;
                state   <= REPLY;
                reply   <= ACK_BYTE;
              end else begin
                counter <= counter + 19'd1;
              end
            end
          end else if (tmo == TMO_LAST) begin
            state <= REPLY;
            reply <= NAK_BYTE;
            tmo   <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        REPLY: begin
          tmo <= '0;
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= reply;
            frame_done <= (reply == ACK_BYTE);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
